push_conditioner: RTL and testbench
===================================

Name: push_conditioner

Overview:
- Conditions the four raw push buttons (PUSH[3:0]) before they reach the game core and the bar-movement logic.
- Per button, it synchronises the raw input, debounces it, and produces one-cycle press and release pulses plus a clean level.
- Optional auto-repeat lets a held button keep stepping a bar.
- Replaces ad-hoc prescaled edge detection in downstream blocks: consumers act on PRESS pulses only.

Parameters:
- DEBOUNCE_CYCLES, 20'd500000: consecutive cycles a synchronised input must differ from the stable state before the stable state flips (10 ms at 50 MHz).
- REPEAT_DELAY, 25'd20000000: cycles from the initial PRESS pulse to the first repeat pulse (400 ms).
- REPEAT_PERIOD, 25'd5000000: cycles between subsequent repeat pulses (100 ms).

Ports:
- CLK  input  1  system clock
- RSTn  input  1  reset; one clock, synchronous, active-low
- PUSH  input  4  raw buttons, active-high (1 = pressed), asynchronous to CLK
- REPEAT_EN  input  4  per-button auto-repeat enable, synchronous
- PRESS  output  4  one-cycle pulse on debounced press, and on each auto-repeat
- RELEASE  output  4  one-cycle pulse on debounced release
- LEVEL  output  4  debounced stable state, 1 = held

Behaviour:
- All state changes occur on posedge CLK. RSTn is sampled only at posedge CLK.
- Reset (RSTn=0 at an edge) clears everything: sync flops, stable state, debounce and repeat counters, PRESS, RELEASE and LEVEL all go to 0.
  - Applies mid-debounce and mid-repeat.
  - A button held through reset is seen as released, so after RSTn rises it produces a fresh PRESS after the normal debounce latency.
- Synchroniser, per bit: two flops, sync1 <= PUSH[i] and sync2 <= sync1. Only sync2 is used downstream.
- Debounce, per bit: counter db_cnt, width 20.
  - sync2 == LEVEL[i]: db_cnt <= 0.
  - sync2 != LEVEL[i] and db_cnt == DEBOUNCE_CYCLES-1: LEVEL[i] <= sync2 and db_cnt <= 0. In the same edge, PRESS[i] <= 1 if sync2 is 1, otherwise RELEASE[i] <= 1.
  - Otherwise db_cnt <= db_cnt + 1.
  - A single-cycle glitch restarts the count, so no pulse is produced.
- Latency: PUSH rising and held steady before edge E0 gives PRESS high in the cycle after edge E0 + DEBOUNCE_CYCLES + 1, and for exactly one cycle. Release latency is identical.
- PRESS and RELEASE default to 0 every cycle unless set as above or by repeat.
- Auto-repeat, per bit: counter rp_cnt, width 25. States per button are IDLE, DELAY and REPEAT.
  - IDLE -> DELAY when the debounced press pulse fires and REPEAT_EN[i]=1; rp_cnt <= 0.
  - DELAY: rp_cnt increments. When rp_cnt == REPEAT_DELAY-1: PRESS[i] <= 1, rp_cnt <= 0, go to REPEAT.
  - REPEAT: rp_cnt increments. When rp_cnt == REPEAT_PERIOD-1: PRESS[i] <= 1, rp_cnt <= 0.
  - DELAY or REPEAT -> IDLE immediately when LEVEL[i] falls (same edge as RELEASE), or when REPEAT_EN[i] is sampled 0. No further repeat pulses.
  - REPEAT_EN rising while already held does not start repeat; repeat arms only at a press.
- Buttons are fully independent. Simultaneous presses on several bits give simultaneous PRESS bits.
- Counters never wrap: each resets at its terminal compare.
- PRESS and RELEASE are never high together on the same bit.

Test Plan (override DEBOUNCE_CYCLES=4, REPEAT_DELAY=10, REPEAT_PERIOD=3):
- Clean press: PUSH=4'b0001 held from cycle 0, REPEAT_EN=0 -> PRESS=4'b0001 for exactly one cycle at cycle 6; LEVEL[0]=1 from cycle 6; no further pulses. Release the button -> RELEASE[0] pulses once, 6 cycles later.
- Bounce rejection: PUSH[1] toggles 1,0,1,0 each cycle, then holds 1 -> no pulse during toggling; a single PRESS[1] 6 cycles after the final rise. A 3-cycle-wide high glitch -> no PRESS, LEVEL stays 0.
- Auto-repeat: REPEAT_EN=4'b0100, PUSH[2] held for 40 cycles -> PRESS[2] at cycles 6, 16, 19, 22, 25, ... every 3 cycles while held. After release, one RELEASE[2] and no more PRESS.
- Repeat disable mid-hold: as above, drop REPEAT_EN[2] at cycle 17 -> no PRESS after cycle 16; RELEASE still pulses on release.
- Simultaneous buttons: PUSH=4'b1010 rising together -> PRESS=4'b1010 in the same cycle; staggered by one cycle -> pulses staggered by one cycle.
- Reset mid-operation: hold PUSH[3], assert RSTn=0 for 2 cycles during the repeat phase -> all outputs 0 while in reset. After RSTn=1 with PUSH[3] still held, a new PRESS[3] comes 6 cycles later and repeat restarts from DELAY.

Source files
------------

// File: rtl/push_conditioner.sv
// Conditions four raw push buttons: two-flop synchroniser, counter debounce,
// one-cycle PRESS/RELEASE pulses, a clean LEVEL and optional auto-repeat.
module push_conditioner #(
   parameter logic [19:0] DEBOUNCE_CYCLES = 20'd500000,
   parameter logic [24:0] REPEAT_DELAY    = 25'd20000000,
   parameter logic [24:0] REPEAT_PERIOD   = 25'd5000000
) (
   input  logic       CLK,
   input  logic       RSTn,
   input  logic [3:0] PUSH,
   input  logic [3:0] REPEAT_EN,
   output logic [3:0] PRESS,
   output logic [3:0] RELEASE,
   output logic [3:0] LEVEL
);

   typedef enum logic [1:0] {
      RP_IDLE   = 2'd0,
      RP_DELAY  = 2'd1,
      RP_REPEAT = 2'd2
   } rp_state_t;

   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_btn
         logic        sync1_q;
         logic        sync2_q;
         logic        level_q;
         logic        level_d;
         logic        press_q;
         logic        press_d;
         logic        release_q;
         logic        release_d;
         logic [19:0] db_cnt_q;
         logic [19:0] db_cnt_d;
         logic [24:0] rp_cnt_q;
         logic [24:0] rp_cnt_d;
         rp_state_t   rp_state_q;
         rp_state_t   rp_state_d;
         logic        db_rise;
         logic        db_fall;
         logic        rep_pulse;

         // Debounce: the stable state flips only after a full run of disagreeing samples.
         always_comb begin
            level_d  = level_q;
            db_cnt_d = db_cnt_q + 20'd1;
            db_rise  = 1'b0;
            db_fall  = 1'b0;
            if (sync2_q == level_q) begin
               db_cnt_d = '0;
            end else if (db_cnt_q == DEBOUNCE_CYCLES - 20'd1) begin
               level_d  = sync2_q;
               db_cnt_d = '0;
               db_rise  = sync2_q;
               db_fall  = ~sync2_q;
            end
         end

         always_comb begin
            rp_state_d = rp_state_q;
            rp_cnt_d   = rp_cnt_q;
            rep_pulse  = 1'b0;
            case (rp_state_q)
               RP_IDLE: begin
                  if (db_rise && REPEAT_EN[gi]) begin
                     rp_state_d = RP_DELAY;
                     rp_cnt_d   = '0;
                  end
               end
               RP_DELAY: begin
                  if (db_fall || !REPEAT_EN[gi]) begin
                     rp_state_d = RP_IDLE;
                     rp_cnt_d   = '0;
                  end else if (rp_cnt_q == REPEAT_DELAY - 25'd1) begin
                     rep_pulse  = 1'b1;
                     rp_cnt_d   = '0;
                     rp_state_d = RP_REPEAT;
                  end else begin
                     rp_cnt_d = rp_cnt_q + 25'd1;
                  end
               end
               RP_REPEAT: begin
                  if (db_fall || !REPEAT_EN[gi]) begin
                     rp_state_d = RP_IDLE;
                     rp_cnt_d   = '0;
                  end else if (rp_cnt_q == REPEAT_PERIOD - 25'd1) begin
                     rep_pulse = 1'b1;
                     rp_cnt_d  = '0;
                  end else begin
                     rp_cnt_d = rp_cnt_q + 25'd1;
                  end
               end
               default: begin
                  rp_state_d = RP_IDLE;
                  rp_cnt_d   = '0;
               end
            endcase
         end

         // A release edge always forces IDLE first, so a repeat pulse never joins it.
         assign press_d   = db_rise | rep_pulse;
         assign release_d = db_fall;

         always_ff @(posedge CLK) begin
            if (!RSTn) begin
               sync1_q    <= 1'b0;
               sync2_q    <= 1'b0;
               level_q    <= 1'b0;
               press_q    <= 1'b0;
               release_q  <= 1'b0;
               db_cnt_q   <= '0;
               rp_cnt_q   <= '0;
               rp_state_q <= RP_IDLE;
            end else begin
               sync1_q    <= PUSH[gi];
               sync2_q    <= sync1_q;
               level_q    <= level_d;
               press_q    <= press_d;
               release_q  <= release_d;
               db_cnt_q   <= db_cnt_d;
               rp_cnt_q   <= rp_cnt_d;
               rp_state_q <= rp_state_d;
            end
         end

         assign PRESS[gi]   = press_q;
         assign RELEASE[gi] = release_q;
         assign LEVEL[gi]   = level_q;

         a_no_press_and_release : assert property (@(posedge CLK) !(press_q && release_q));
      end
   endgenerate

endmodule

// File: tb/tb_push_conditioner.sv
// Directed bench for push_conditioner with short debounce/repeat timings;
// per-cycle expectation table plus a hand-written reset-mid-debounce sequence.
module tb_push_conditioner;

   logic       CLK;
   logic       RSTn;
   logic [3:0] PUSH;
   logic [3:0] REPEAT_EN;
   logic [3:0] PRESS;
   logic [3:0] RELEASE;
   logic [3:0] LEVEL;

   int tests_run;
   int tests_failed;

   push_conditioner #(
      .DEBOUNCE_CYCLES(20'd4),
      .REPEAT_DELAY   (25'd10),
      .REPEAT_PERIOD  (25'd3)
   ) dut (
      .CLK      (CLK),
      .RSTn     (RSTn),
      .PUSH     (PUSH),
      .REPEAT_EN(REPEAT_EN),
      .PRESS    (PRESS),
      .RELEASE  (RELEASE),
      .LEVEL    (LEVEL)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   typedef struct {
      logic [3:0] push;
      logic [3:0] ren;
      logic       rstn;
      logic [3:0] press;
      logic [3:0] rel;
      logic [3:0] lvl;
   } vec_t;

   vec_t vecs[$];

   // Append n identical cycles: inputs applied before an edge, outputs expected after it.
   function automatic void vn(int n, logic [3:0] push, logic [3:0] ren, logic rstn,
                              logic [3:0] press, logic [3:0] rel, logic [3:0] lvl);
      vec_t v;
      v.push  = push;
      v.ren   = ren;
      v.rstn  = rstn;
      v.press = press;
      v.rel   = rel;
      v.lvl   = lvl;
      for (int k = 0; k < n; k++) vecs.push_back(v);
   endfunction

   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   task automatic chk(string name, int row, logic [3:0] got, logic [3:0] exp);
      tests_run++;
      if (got !== exp) begin
         tests_failed++;
         $display("FAIL row %0d %s: got %b want %b", row, name, got, exp);
      end
   endtask

   task automatic chk_int(string name, int got, int exp);
      tests_run++;
      if (got != exp) begin
         tests_failed++;
         $display("FAIL %s: got %0d want %0d", name, got, exp);
      end
   endtask

   initial begin
      int  n;
      bit  got_press;
      bit  early;
      tests_run    = 0;
      tests_failed = 0;
      RSTn      = 1'b0;
      PUSH      = 4'b0000;
      REPEAT_EN = 4'b0000;

      // Reset state
      vn(2, 4'b0000, 4'b0000, 1'b0, 4'b0000, 4'b0000, 4'b0000);
      vn(2, 4'b0000, 4'b0000, 1'b1, 4'b0000, 4'b0000, 4'b0000);

      // Clean press then release on bit 0
      vn(5, 4'b0001, 4'b0000, 1'b1, 4'b0000, 4'b0000, 4'b0000);
      vn(1, 4'b0001, 4'b0000, 1'b1, 4'b0001, 4'b0000, 4'b0001);
      vn(4, 4'b0001, 4'b0000, 1'b1, 4'b0000, 4'b0000, 4'b0001);
      vn(5, 4'b0000, 4'b0000, 1'b1, 4'b0000, 4'b0000, 4'b0001);
      vn(1, 4'b0000, 4'b0000, 1'b1, 4'b0000, 4'b0001, 4'b0000);
      vn(3, 4'b0000, 4'b0000, 1'b1, 4'b0000, 4'b0000, 4'b0000);

      // Bounce on bit 1, then steady hold: press 6 cycles after final rise
      vn(1, 4'b0010, 4'b0000, 1'b1, 4'b0000, 4'b0000, 4'b0000);
      vn(1, 4'b0000, 4'b0000, 1'b1, 4'b0000, 4'b0000, 4'b0000);
      vn(1, 4'b0010, 4'b0000, 1'b1, 4'b0000, 4'b0000, 4'b0000);
      vn(1, 4'b0000, 4'b0000, 1'b1, 4'b0000, 4'b0000, 4'b0000);
      vn(5, 4'b0010, 4'b0000, 1'b1, 4'b0000, 4'b0000, 4'b0000);
      vn(1, 4'b0010, 4'b0000, 1'b1, 4'b0010, 4'b0000, 4'b0010);
      vn(3, 4'b0010, 4'b0000, 1'b1, 4'b0000, 4'b0000, 4'b0010);
      vn(5, 4'b0000, 4'b0000, 1'b1, 4'b0000, 4'b0000, 4'b0010);
      vn(1, 4'b0000, 4'b0000, 1'b1, 4'b0000, 4'b0010, 4'b0000);
      vn(2, 4'b0000, 4'b0000, 1'b1, 4'b0000, 4'b0000, 4'b0000);

      // 3-cycle glitch is rejected
      vn(3, 4'b0010, 4'b0000, 1'b1, 4'b0000, 4'b0000, 4'b0000);
      vn(6, 4'b0000, 4'b0000, 1'b1, 4'b0000, 4'b0000, 4'b0000);

      // 4-cycle pulse is just long enough: press at 6, release at 10
      vn(4, 4'b0010, 4'b0000, 1'b1, 4'b0000, 4'b0000, 4'b0000);
      vn(1, 4'b0000, 4'b0000, 1'b1, 4'b0000, 4'b0000, 4'b0000);
      vn(1, 4'b0000, 4'b0000, 1'b1, 4'b0010, 4'b0000, 4'b0010);
      vn(3, 4'b0000, 4'b0000, 1'b1, 4'b0000, 4'b0000, 4'b0010);
      vn(1, 4'b0000, 4'b0000, 1'b1, 4'b0000, 4'b0010, 4'b0000);
      vn(2, 4'b0000, 4'b0000, 1'b1, 4'b0000, 4'b0000, 4'b0000);

      // Auto-repeat on bit 2: held 40 cycles, released at 41; repeats continue
      // until the debounced release at 46, where the due repeat is suppressed
      for (int s = 1; s <= 52; s++) begin
         bit p;
         p = (s inside {6, 16, 19, 22, 25, 28, 31, 34, 37, 40, 43});
         vn(1, (s <= 40) ? 4'b0100 : 4'b0000, 4'b0100, 1'b1,
            p ? 4'b0100 : 4'b0000, (s == 46) ? 4'b0100 : 4'b0000,
            (s >= 6 && s <= 45) ? 4'b0100 : 4'b0000);
      end

      // Repeat disabled at cycle 17: no press after 16, release still pulses
      for (int s = 1; s <= 33; s++) begin
         vn(1, (s <= 25) ? 4'b0100 : 4'b0000, (s <= 16) ? 4'b0100 : 4'b0000, 1'b1,
            (s == 6 || s == 16) ? 4'b0100 : 4'b0000, (s == 31) ? 4'b0100 : 4'b0000,
            (s >= 6 && s <= 30) ? 4'b0100 : 4'b0000);
      end

      // Simultaneous press/release on bits 3 and 1
      vn(5, 4'b1010, 4'b0000, 1'b1, 4'b0000, 4'b0000, 4'b0000);
      vn(1, 4'b1010, 4'b0000, 1'b1, 4'b1010, 4'b0000, 4'b1010);
      vn(2, 4'b1010, 4'b0000, 1'b1, 4'b0000, 4'b0000, 4'b1010);
      vn(5, 4'b0000, 4'b0000, 1'b1, 4'b0000, 4'b0000, 4'b1010);
      vn(1, 4'b0000, 4'b0000, 1'b1, 4'b0000, 4'b1010, 4'b0000);
      vn(2, 4'b0000, 4'b0000, 1'b1, 4'b0000, 4'b0000, 4'b0000);

      // Staggered by one cycle
      vn(1, 4'b1000, 4'b0000, 1'b1, 4'b0000, 4'b0000, 4'b0000);
      vn(4, 4'b1010, 4'b0000, 1'b1, 4'b0000, 4'b0000, 4'b0000);
      vn(1, 4'b1010, 4'b0000, 1'b1, 4'b1000, 4'b0000, 4'b1000);
      vn(1, 4'b1010, 4'b0000, 1'b1, 4'b0010, 4'b0000, 4'b1010);
      vn(2, 4'b1010, 4'b0000, 1'b1, 4'b0000, 4'b0000, 4'b1010);
      vn(5, 4'b0000, 4'b0000, 1'b1, 4'b0000, 4'b0000, 4'b1010);
      vn(1, 4'b0000, 4'b0000, 1'b1, 4'b0000, 4'b1010, 4'b0000);
      vn(2, 4'b0000, 4'b0000, 1'b1, 4'b0000, 4'b0000, 4'b0000);

      // Reset during repeat on bit 3 (cycles 20-21); fresh press at 27, repeat from DELAY
      for (int s = 1; s <= 50; s++) begin
         vn(1, (s <= 41) ? 4'b1000 : 4'b0000, 4'b1000, !(s == 20 || s == 21),
            (s inside {6, 16, 19, 27, 37, 40, 43, 46}) ? 4'b1000 : 4'b0000,
            (s == 47) ? 4'b1000 : 4'b0000,
            ((s >= 6 && s <= 19) || (s >= 27 && s <= 46)) ? 4'b1000 : 4'b0000);
      end

      for (int i = 0; i < vecs.size(); i++) begin
         PUSH      = vecs[i].push;
         REPEAT_EN = vecs[i].ren;
         RSTn      = vecs[i].rstn;
         step();
         $display("[TB] row %0d push=%b ren=%b rstn=%b press=%b release=%b level=%b",
                  i, PUSH, REPEAT_EN, RSTn, PRESS, RELEASE, LEVEL);
         chk("press", i, PRESS, vecs[i].press);
         chk("release", i, RELEASE, vecs[i].rel);
         chk("level", i, LEVEL, vecs[i].lvl);
      end

      // Reset in the middle of a debounce count restarts the full latency
      REPEAT_EN = 4'b0000;
      PUSH      = 4'b0001;
      RSTn      = 1'b1;
      early     = 1'b0;
      for (int k = 0; k < 3; k++) begin
         step();
         if (PRESS[0]) early = 1'b1;
      end
      RSTn = 1'b0;
      step();
      chk_int("no_press_before_reset", int'(early), 0);
      chk("level_in_reset", -1, LEVEL, 4'b0000);
      RSTn      = 1'b1;
      n         = 0;
      got_press = 1'b0;
      while (!got_press && n < 20) begin
         step();
         n++;
         if (PRESS[0]) got_press = 1'b1;
      end
      $display("[TB] reset-mid-debounce press after %0d cycles", n);
      chk_int("press_latency_after_reset", n, 6);
      PUSH = 4'b0000;
      for (int k = 0; k < 10; k++) step();
      chk("idle_after_release", -1, LEVEL, 4'b0000);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
